// File: rtl/shift_sequencer.sv
// Command-driven left-shift sequencer: loads a seed bit into bit 0, then shifts
// left once every DIV clocks for a commanded count, pulsing done at the end.
module shift_sequencer #(
    parameter int WIDTH = 6,
    parameter int CW    = 3,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             seed_bit,
    input  logic [CW-1:0]    shift_cnt,
    input  logic             abort,
    output logic [WIDTH-1:0] number,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_rem;
    logic [DW-1:0]    r_div;
    logic [WIDTH-1:0] r_number;
    logic             r_overflow;
    logic             r_seed;
    logic             w_accept;
    logic             w_load;
    logic             w_step;
    logic             w_div_last;

    assign w_div_last = (r_div == DIV_LAST);

    // Abort wins over both the load and a pending shift step.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_accept     = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_load       = 1'b1;
                    w_state_next = (r_rem == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (w_div_last) begin
                    w_step = 1'b1;
                    if (r_rem == CW'(1)) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= S_IDLE;
            r_rem      <= '0;
            r_div      <= '0;
            r_number   <= '0;
            r_overflow <= 1'b0;
            r_seed     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Operands are captured at acceptance so later input changes are harmless.
            if (w_accept) begin
                r_rem  <= shift_cnt;
                r_seed <= seed_bit;
            end
            if (w_load) begin
                r_number   <= {{(WIDTH-1){1'b0}}, r_seed};
                r_overflow <= 1'b0;
                r_div      <= '0;
            end
            if (r_state == S_SHIFT && !abort) begin
                r_div <= w_div_last ? '0 : r_div + 1'b1;
            end
            if (w_step) begin
                r_number   <= {r_number[WIDTH-2:0], 1'b0};
                r_overflow <= r_overflow | r_number[WIDTH-1];
                r_rem      <= r_rem - 1'b1;
            end
        end
    end

    assign number   = r_number;
    assign busy     = (r_state == S_LOAD) || (r_state == S_SHIFT);
    assign done     = (r_state == S_DONE);
    assign overflow = r_overflow;

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Command-driven controller for the 6-bit left-shift datapath. It accepts a start command with a seed bit and a shift count. It then loads the seed into bit 0 and shifts the register left once per step until the count is exhausted, then signals completion. A host sits on one side; the downstream consumer reads `number`, `busy`, `done` and `overflow`.

Parameters:
- WIDTH, 6: shift register width in bits.
- CW, 3: width of the shift count field. Counts 0..2^CW-1 are legal.
- DIV, 1: clock cycles per shift step. Must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr_n  input  1  asynchronous, active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- seed_bit  input  1  value loaded into number[0] at LOAD.
- shift_cnt  input  CW  number of left shifts to perform.
- abort  input  1  cancels an operation in progress.
- number  output  WIDTH  shift register contents.
- busy  output  1  high in LOAD and SHIFT.
- done  output  1  one-cycle completion pulse.
- overflow  output  1  sticky flag: a 1 was shifted out of number[WIDTH-1] during the current operation.

Behaviour:
- Reset (clr_n=0, asynchronous, takes effect immediately, including mid-operation):
  - state=IDLE, number=0, busy=0, done=0, overflow=0.
  - Step divider and remaining-count register cleared.
- States:
  - IDLE: busy=0, done=0, number holds its value.
  - LOAD: busy=1.
  - SHIFT: busy=1.
  - DONE: busy=0, done=1, for exactly one cycle.
- IDLE: start=1 and abort=0 at edge k -> latch shift_cnt into rem, go to LOAD. start with abort=1 -> stay in IDLE.
- LOAD, one cycle, edge k+1:
  - number <= {WIDTH-1 zeros, seed_bit}; overflow <= 0; divider cleared.
  - rem==0 -> DONE; otherwise -> SHIFT.
- SHIFT: divider counts 0..DIV-1. On each edge where divider==DIV-1:
  - number <= number<<1, zero-fill at bit 0.
  - overflow <= overflow | number[WIDTH-1].
  - rem <= rem-1.
  - If rem was 1, go to DONE.
- DONE: back to IDLE on the next edge. start during DONE is ignored; it is not queued.
- Latency: done is high in the cycle following edge k+1+shift_cnt*DIV. For shift_cnt=0, done is high after edge k+1.
- Counts >= WIDTH are legal. Once the seed passes bit WIDTH-1, number reads all-zero. overflow=1 only if seed_bit=1.
- abort in LOAD or SHIFT -> IDLE on the next edge:
  - number and overflow are frozen at their current values.
  - No done pulse.
  - abort has priority over a shift step in the same cycle.
- abort in IDLE or DONE has no effect.
- start, seed_bit and shift_cnt are ignored outside IDLE. Operand changes mid-operation do not affect the operation in progress.
- Back-to-back: the earliest new start is the IDLE cycle after DONE, giving a minimum of 3 + shift_cnt*DIV cycles per command.

Test Plan:
1. Reset -> number=000000, busy=0, done=0, overflow=0. Release clr_n, idle 3 cycles -> outputs unchanged.
2. DIV=1, start with seed_bit=1, shift_cnt=5 -> number goes 000001, 000010 … 100000. done pulses exactly once, 6 edges after the start edge. overflow=0, busy low in the done cycle.
3. seed_bit=1, shift_cnt=7 -> final number=000000, overflow=1, done once. Repeat with seed_bit=0 -> number=000000, overflow=0.
4. shift_cnt=0, seed_bit=1 -> number=000001, done in the cycle after LOAD, with no shift.
5. Start seed_bit=1, shift_cnt=6; assert abort after 2 shifts -> number=000100 holds, busy=0 next cycle, no done. Then a start in the same cycle as abort while IDLE -> no operation begins.
6. Assert clr_n low mid-SHIFT -> all outputs 0 immediately. With DIV=3, shift_cnt=2 -> shifts at edges k+4 and k+7, done after edge k+7. A start pulsed during busy is ignored.
